// File: rtl/axi_lite_pkg.sv
// AXI4-Lite shared definitions.
// Response codes and the manager FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } axi_lite_master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite manager.
// One command in, AW/W/B or AR/R out, one response back.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("axi_lite_master: only DATA_WIDTH=32 is supported");
  end

  axi_lite_master_state_t state, state_n;

  logic accept;
  logic aw_left;
  logic w_left;
  logic b_hs;
  logic r_hs;

  assign accept  = cmd_valid && cmd_ready;
  assign aw_left = m_axi_awvalid && !m_axi_awready;
  assign w_left  = m_axi_wvalid && !m_axi_wready;
  assign b_hs    = m_axi_bvalid && m_axi_bready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_n;
  end

  // Next-state: each state waits on its own channel handshake.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = cmd_write ? WRITE : RD_ADDR;
      WRITE:   if (!aw_left && !w_left) state_n = WR_RESP;
      WR_RESP: if (b_hs) state_n = RESP;
      RD_ADDR: if (m_axi_arvalid && m_axi_arready) state_n = RD_DATA;
      RD_DATA: if (r_hs) state_n = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control outputs registered from the next state, so no valid
  // ever depends combinationally on a ready.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      cmd_ready     <= (state_n == IDLE);
      busy          <= (state_n != IDLE);
      rsp_valid     <= (state_n == RESP);
      m_axi_awvalid <= (accept && cmd_write) || aw_left;
      m_axi_wvalid  <= (accept && cmd_write) || w_left;
      m_axi_bready  <= (state_n == WR_RESP);
      m_axi_arvalid <= (state_n == RD_ADDR);
      m_axi_rready  <= (state_n == RD_DATA);
    end
  end

  // Capture command fields on accept and the result on B/R.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      m_axi_araddr <= '0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
    end else begin
      if (accept) begin
        rsp_write <= cmd_write;
        if (cmd_write) begin
          m_axi_awaddr <= cmd_addr;
          m_axi_wdata  <= cmd_wdata;
          m_axi_wstrb  <= cmd_wstrb;
        end else begin
          m_axi_araddr <= cmd_addr;
        end
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
      end
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master.
// Directed table, reset corners, and random traffic vs a memory model.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int BUDGET = 64;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    int          bd;
    int          ard;
    int          rd;
    int          hold;
    logic [1:0]  resp;
  } txn_t;

  typedef struct {
    txn_t        t;
    int          lat;
    logic [31:0] erd;
    logic [1:0]  ers;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] sub_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  vec_t vec [9];

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sub_peek(input logic [31:0] a);
    return sub_mem.exists(a) ? sub_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_peek(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Transaction-level expectation: latency from the delays, data from memory.
  task automatic model(input txn_t t, output int lat,
                       output logic [31:0] erd, output logic [1:0] ers);
    ers = t.resp;
    if (t.write) begin
      lat = 3 + ((t.awd > t.wd) ? t.awd : t.wd) + t.bd;
      erd = 32'h0;
      ref_mem[t.addr] = merge(ref_peek(t.addr), t.wdata, t.strb);
    end else begin
      lat = 3 + t.ard + t.rd;
      erd = ref_peek(t.addr);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input int awd, input int wd, input int bd,
                              input int ard, input int rd, input int hold,
                              input logic [1:0] rs, input int lat,
                              input logic [31:0] erd, input logic [1:0] ers);
    vec_t v;
    v.t.write = w;
    v.t.addr  = a;
    v.t.wdata = d;
    v.t.strb  = s;
    v.t.awd   = awd;
    v.t.wd    = wd;
    v.t.bd    = bd;
    v.t.ard   = ard;
    v.t.rd    = rd;
    v.t.hold  = hold;
    v.t.resp  = rs;
    v.lat     = lat;
    v.erd     = erd;
    v.ers     = ers;
    return v;
  endfunction

  task automatic run_txn(input txn_t t, input int exp_lat,
                         input logic [31:0] exp_rd, input logic [1:0] exp_rs);
    int n, aw_cnt, w_cnt, ar_cnt, x_cnt, hold_cnt, rsp_first;
    bit acc, aw_done, w_done, ar_done, fin, got;
    logic [31:0] cap_addr, cap_data, r_rd;
    logic [3:0]  cap_strb;
    logic [1:0]  r_rs;
    logic        r_wr;
    acc = 0;
    n = 0;
    for (int k = 0; k < BUDGET && !acc; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = t.write;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      cmd_wstrb = t.strb;
      if (cmd_ready) begin
        acc = 1;
        n = cyc;
      end
    end
    chk("cmd_accept", 32'(acc), 32'd1);
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    aw_done = 0; w_done = 0; ar_done = 0; fin = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; x_cnt = 0;
    cap_addr = 0; cap_data = 0; cap_strb = 0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      @(negedge clk);
      cmd_valid     = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_rvalid  = 1'b0;
      if (c == 0) begin
        chk("busy", 32'(busy), 32'd1);
        if (t.write) chk("no_ar_on_write", 32'(m_axi_arvalid), 32'd0);
        else chk("no_aw_on_read", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd0);
      end
      if (t.write) begin
        if (aw_done && w_done) begin
          chk("bready", 32'(m_axi_bready), 32'd1);
          m_axi_bvalid = (x_cnt >= t.bd);
          m_axi_bresp  = t.resp;
          x_cnt++;
          if (m_axi_bvalid) fin = 1;
        end else begin
          chk("bready_early", 32'(m_axi_bready), 32'd0);
          if (!aw_done) begin
            chk("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
            chk("awaddr", m_axi_awaddr, t.addr);
            m_axi_awready = (aw_cnt >= t.awd);
            aw_cnt++;
            if (m_axi_awready) begin
              aw_done = 1;
              cap_addr = m_axi_awaddr;
            end
          end else begin
            chk("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
          end
          if (!w_done) begin
            chk("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
            chk("wdata", m_axi_wdata, t.wdata);
            chk("wstrb", 32'(m_axi_wstrb), 32'(t.strb));
            m_axi_wready = (w_cnt >= t.wd);
            w_cnt++;
            if (m_axi_wready) begin
              w_done = 1;
              cap_data = m_axi_wdata;
              cap_strb = m_axi_wstrb;
            end
          end else begin
            chk("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
          end
          if (aw_done && w_done)
            sub_mem[cap_addr] = merge(sub_peek(cap_addr), cap_data, cap_strb);
        end
      end else begin
        if (ar_done) begin
          chk("rready", 32'(m_axi_rready), 32'd1);
          m_axi_rvalid = (x_cnt >= t.rd);
          m_axi_rdata  = sub_peek(cap_addr);
          m_axi_rresp  = t.resp;
          x_cnt++;
          if (m_axi_rvalid) fin = 1;
        end else begin
          chk("rready_early", 32'(m_axi_rready), 32'd0);
          chk("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
          chk("araddr", m_axi_araddr, t.addr);
          m_axi_arready = (ar_cnt >= t.ard);
          ar_cnt++;
          if (m_axi_arready) begin
            ar_done = 1;
            cap_addr = m_axi_araddr;
          end
        end
      end
    end
    chk("axi_done", 32'(fin), 32'd1);
    rsp_first = -1;
    got = 0;
    hold_cnt = 0;
    r_wr = 0; r_rd = 0; r_rs = 0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge clk);
      m_axi_bvalid = 1'b0;
      m_axi_rvalid = 1'b0;
      rsp_ready    = 1'b0;
      if (rsp_valid) begin
        if (rsp_first < 0) begin
          rsp_first = cyc;
          r_wr = rsp_write;
          r_rd = rsp_rdata;
          r_rs = rsp_resp;
          chk("rsp_latency", 32'(rsp_first - n), 32'(exp_lat));
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, r_rd);
          chk("rsp_ctl_stable", 32'({rsp_write, rsp_resp}), 32'({r_wr, r_rs}));
        end
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        rsp_ready = (hold_cnt >= t.hold);
        hold_cnt++;
        if (rsp_ready) got = 1;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("rsp_write", 32'(r_wr), 32'(t.write));
    chk("rsp_rdata", r_rd, exp_rd);
    chk("rsp_resp", 32'(r_rs), 32'(exp_rs));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("idle_after", 32'({cmd_ready, busy}), 32'(2'b10));
  endtask

  initial begin
    bit acc;
    int lat;
    logic [31:0] erd;
    logic [1:0]  ers;
    txn_t t;

    rst = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h4; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;

    // reset with a command offered
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", 32'({cmd_ready, m_axi_awvalid, m_axi_wvalid,
                          m_axi_arvalid, m_axi_bready, m_axi_rready,
                          rsp_valid, busy}), 32'd0);
      chk("rst_data", m_axi_awaddr | m_axi_wdata | m_axi_araddr | rsp_rdata,
          32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rst_release_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("first_ready", 32'(cmd_ready), 32'd1);

    // directed table
    vec[0] = mk(1'b1, 32'h4, 32'hA5A5_00FF, 4'hF, 0, 0, 0, 0, 0, 0,
                RESP_OKAY, 3, 32'h0, RESP_OKAY);
    vec[1] = mk(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
                RESP_OKAY, 3, 32'hA5A5_00FF, RESP_OKAY);
    vec[2] = mk(1'b1, 32'h8, 32'h1234_5678, 4'hF, 5, 0, 0, 0, 0, 0,
                RESP_OKAY, 8, 32'h0, RESP_OKAY);
    vec[3] = mk(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 3, 2, 0,
                RESP_SLVERR, 8, 32'h1234_5678, RESP_SLVERR);
    vec[4] = mk(1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0011, 0, 4, 2, 0, 0, 0,
                RESP_DECERR, 9, 32'h0, RESP_DECERR);
    vec[5] = mk(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 4,
                RESP_EXOKAY, 3, 32'hA5A5_BEEF, RESP_EXOKAY);
    vec[6] = mk(1'b1, 32'hC, 32'hCAFE_F00D, 4'b1000, 2, 2, 0, 0, 0, 4,
                RESP_SLVERR, 5, 32'h0, RESP_SLVERR);
    vec[7] = mk(1'b0, 32'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
                RESP_DECERR, 3, 32'hCA00_0000, RESP_DECERR);
    vec[8] = mk(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 1, 1, 0,
                RESP_OKAY, 5, 32'h0, RESP_OKAY);
    for (int i = 0; i < 9; i++) begin
      model(vec[i].t, lat, erd, ers);
      run_txn(vec[i].t, vec[i].lat, vec[i].erd, vec[i].ers);
    end

    // reset while AW and W are stalled
    acc = 0;
    for (int k = 0; k < BUDGET && !acc; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'h20; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      if (cmd_ready) acc = 1;
    end
    chk("abort_accept", 32'(acc), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_pre_valids", 32'({m_axi_awvalid, m_axi_wvalid}), 32'(2'b11));
    @(negedge clk);
    chk("abort_pre_hold", 32'({m_axi_awvalid, m_axi_wvalid}), 32'(2'b11));
    rst = 1'b1;
    #1;
    chk("abort_drop", 32'({m_axi_awvalid, m_axi_wvalid, busy, cmd_ready,
                           rsp_valid}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_in_rst", 32'({m_axi_awvalid, m_axi_wvalid, rsp_valid}),
          32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({cmd_ready, busy, rsp_valid, m_axi_awvalid}),
        32'(4'b1000));
    @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

    // random traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      t.write = 1'($urandom_range(0, 1));
      t.addr  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      t.wdata = $urandom;
      t.strb  = 4'($urandom);
      t.awd   = int'($urandom_range(0, 4));
      t.wd    = int'($urandom_range(0, 4));
      t.bd    = int'($urandom_range(0, 3));
      t.ard   = int'($urandom_range(0, 4));
      t.rd    = int'($urandom_range(0, 3));
      t.hold  = int'($urandom_range(0, 3));
      t.resp  = 2'($urandom);
      model(t, lat, erd, ers);
      run_txn(t, lat, erd, ers);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator: the manager-side counterpart of the UART AXI4-Lite subordinate.
- Converts a simple valid/ready command port (one read or write per command) into AW/W/B or AR/R channel traffic.
- Returns data and response through a valid/ready response port.
- Used as the bench/CPU-side driver for UART register access, and as the DUT that drives the subordinate in closed-loop formal runs.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, m_axi_awaddr, m_axi_araddr
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8; only 32 is supported (elaboration error otherwise)

Ports:
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP
- m_axi_awaddr, m_axi_awvalid (out), m_axi_awready (in): AW channel
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid (out), m_axi_wready (in): W channel
- m_axi_bresp, m_axi_bvalid (in), m_axi_bready (out): B channel
- m_axi_araddr, m_axi_arvalid (out), m_axi_arready (in): AR channel
- m_axi_rdata, m_axi_rresp, m_axi_rvalid (in), m_axi_rready (out): R channel
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-high; all outputs registered.
  - While m_axi_areset is high: all *valid/*ready outputs, busy, rsp_* and all address/data outputs = 0.
  - FSM = IDLE.
  - cmd_ready goes high the first clock after reset deasserts.
- Reset mid-transaction aborts immediately: channels drop to 0 and no response is produced.
- FSM states: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1; no other state asserts cmd_ready.
  - On cmd_valid && cmd_ready, register addr/wdata/wstrb/write.
  - Next state is WRITE if cmd_write, else RD_ADDR.
  - The AXI valids rise the cycle after acceptance.
- WRITE:
  - awvalid and wvalid are asserted together and dropped independently, each on its own handshake.
  - Leave WRITE when both handshakes have completed; simultaneous or either order is legal.
  - awready is allowed to come many cycles before or after wready.
- WR_RESP:
  - bready = 1 only in this state.
  - On bvalid: capture bresp, rsp_rdata = 0, go to RESP.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1 only in this state.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - Then go to IDLE, with rsp_valid = 0 the next cycle.
- Protocol obligations (checked by the AXI property set):
  - Once asserted, any valid stays high until its ready.
  - addr/data/strb stay stable while valid && !ready.
  - No valid depends combinationally on any ready.
- Best-case latency, ready-always subordinate:
  - Write: cmd accepted at cycle N; AW/W handshake at N+1; B handshake at N+2; rsp_valid at N+3.
  - Read: AR at N+1; R handshake at N+2; rsp_valid at N+3.
- Responses:
  - SLVERR/DECERR are passed through unaltered; the block does not retry.
  - No timeout: a stalled subordinate holds the FSM indefinitely.
- Read data is captured and returned for any RRESP value.

Decomposition:
- Shared package axi_lite_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - state enum typedef axi_lite_master_state_t
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Reset with cmd_valid=1 held → all AXI valids=0, cmd_ready=0 while reset is high; cmd_ready=1 one cycle after release.
- Write 0x0000_0004, wdata 0xA5A5_00FF, strb 4'hF, subordinate always ready, bresp OKAY → awvalid/wvalid at N+1, bready at N+2, rsp_valid at N+3 with rsp_resp=0, rsp_write=1.
- Write with awready delayed 5 cycles and wready immediate → wvalid drops after 1 cycle; awvalid held 6 cycles with awaddr stable; exactly one response.
- Read 0x0000_0008, arready delayed 3 cycles, rvalid 2 cycles after AR with rdata 0x1234_5678, rresp SLVERR → rsp_rdata=0x1234_5678, rsp_resp=2'b10.
- rsp_ready held low 4 cycles in RESP → rsp_valid and rsp_* stable; cmd_ready=0 throughout; next command accepted only after the rsp handshake.
- Reset asserted while awvalid=1 and awready=0 → awvalid and wvalid drop to 0 within the same cycle; no rsp_valid; a clean IDLE state follows.
